tlb_mmu: RTL and testbench
==========================

# tlb_mmu

Parametrised page-translation unit that replaces the CPU's flat internal page-table array with a small fully-associative TLB backed by a hardware page-table walk into main memory. It sits between the CPU's MAR and the external RAM address bus. It translates each virtual address into a physical address and raises page or protection faults toward the irq encoder. Paging enable, page-table base and user/supervisor mode come from the control register and the page-table-base write path.

## Interface
- VADDR_W, 16: virtual address width.
- PADDR_W, 19: physical address width.
- PAGE_BITS, 11: page offset width; VPN_W = VADDR_W-PAGE_BITS, PFN_W = PADDR_W-PAGE_BITS.
- PTE_W, 16: page-table entry width; PFN occupies pte[PTE_W-1 -: PFN_W]; requires PFN_W <= PTE_W-3.
- TLB_ENTRIES, 4: TLB depth, power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- paging_en  in  1  translation enable (control-register bit 2).
- umode  in  1  requester is in user mode.
- ptb_load  in  1  load ptb_in; also flushes the TLB.
- ptb_in  in  PADDR_W  new page-table base, physical byte address.
- flush  in  1  invalidate all TLB entries.
- req_valid  in  1  translation request.
- req_ready  out  1  high only in IDLE.
- req_vaddr  in  VADDR_W  virtual byte address.
- req_write  in  1  access is a store.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_paddr  out  PADDR_W  translated address; 0 on a fault.
- rsp_page_fault  out  1  PTE not present.
- rsp_prot_fault  out  1  protection violation.
- mem_req  out  1  page-table read request.
- mem_addr  out  PADDR_W  PTE address.
- mem_rdata  in  PTE_W  PTE read data.
- mem_ack  in  1  read data valid; sampled only while mem_req is high.

## Operation
- PTE bits:
  - bit0 present.
  - bit1 supervisor-only.
  - bit2 writable (see Configuration).
  - top PFN_W bits are the frame number.
- States: IDLE, LOOKUP, WALK, RESP.
- **IDLE**
  - req_ready=1.
  - On req_valid, register vaddr, write and umode, then go to LOOKUP.
- **LOOKUP**
  - If paging_en=0: rsp_paddr = zero-extended vaddr (truncated if VADDR_W > PADDR_W), no faults, go to RESP.
  - If a valid entry's VPN matches (hit): take PFN and flags from the TLB, go to RESP.
  - Otherwise (miss): go to WALK.
- **WALK**
  - mem_req=1 and mem_addr = ptb + {vpn,1'b0} mod 2^PADDR_W, both held stable until mem_ack.
  - On mem_ack, latch the PTE.
  - If present and no flush occurred during the walk, fill the entry at the round-robin pointer and advance the pointer, wrapping at TLB_ENTRIES-1.
  - Go to RESP.
- Non-present PTEs are never cached.
- **Fault priority** (checked on hit and after a walk):
  1. Not present: page_fault.
  2. umode and supervisor-only: prot_fault.
  3. Write-protect violation: prot_fault.
- Only one fault flag is ever set.
- **RESP**: rsp_valid=1 for exactly one cycle, then go to IDLE.
- **flush / ptb_load**
  - Clear all valid bits at the edge, in any state.
  - If asserted in LOOKUP, the lookup sees the entries as invalid and misses.
  - If asserted during WALK, the fill is suppressed but the response is still delivered.
  - ptb_load during WALK does not change mem_addr of the outstanding read.
- A hit and a fill are never simultaneous, because fills happen only from WALK.

## Timing
- Reset values:
  - state IDLE; req_ready=1 at reset.
  - rsp_valid=0, rsp_paddr=0, both faults=0.
  - mem_req=0, mem_addr=0.
  - all TLB valid bits 0, round-robin pointer 0, ptb=0.
- Hit or bypass: request accepted at edge N, rsp_valid high in cycle N+2.
- Miss: mem_req rises in cycle N+2; rsp_valid is high the cycle after the edge that samples mem_ack; minimum miss latency is 4 cycles.
- Reset asserted mid-walk drops mem_req immediately (asynchronous); any late mem_ack is ignored.
- Outputs rsp_* are registered and valid only while rsp_valid=1.

## Configuration
- TLB_WRITE_PROT_EN
  - Defined: PTE bit2 is stored in the TLB; req_write=1 to a page with bit2=0 raises rsp_prot_fault.
  - Undefined: bit2 is neither stored nor checked; writes are never faulted for writability.

## Structure
- Package mmu_pkg holds:
  - PTE bit-position constants (PTE_PRESENT=0, PTE_SUPER=1, PTE_WRITE=2).
  - the state enum.
  - a TLB-entry struct typedef (valid, vpn, pfn, super, write).
- One sub-module, tlb_array:
  - fully-associative storage, match logic and round-robin pointer.
  - ports for lookup VPN, hit/PFN/flags out, fill, flush.
  - state in tlb_mmu top: the FSM, walk address generation and fault logic.

## Test plan
- paging_en=0, vaddr 16'h1234 -> rsp_paddr 19'h01234 in cycle N+2, no fault, no mem_req.
- paging_en=1, ptb=19'h00100, vaddr 16'h0804 (VPN 1) -> mem_addr 19'h00102; mem_rdata 16'h2A01 -> rsp_paddr 19'h15004; repeating the same VPN hits with no mem_req.
- PTE 16'h2A00 (not present) -> page_fault=1, paddr 0; a re-request walks again, proving no fill.
- umode=1, PTE 16'h2A03 -> prot_fault=1; the same page with umode=0 hits with no fault. With TLB_WRITE_PROT_EN, a write to PTE 16'h2A01 -> prot_fault; PTE 16'h2A05 -> no fault.
- Fill five distinct VPNs with TLB_ENTRIES=4 -> the first VPN is evicted and re-walked. flush pulsed during WALK -> response delivered but the next request to that VPN walks again.
- Reset asserted while mem_req=1 -> mem_req=0 the same cycle; TLB empty afterward.

Source files
------------

// File: rtl/mmu_pkg.sv
// ---------------------------------------------------------------------------
// mmu_pkg
// Shared definitions for the tlb_mmu page-translation unit:
//   - PTE bit positions (present / supervisor-only / writable)
//   - default address geometry and the derived VPN / PFN widths
//   - FSM state enum
//   - TLB entry struct
//   - fault-priority helper used on both the hit path and the walk path
// ---------------------------------------------------------------------------
package mmu_pkg;

  localparam int PTE_PRESENT = 0;
  localparam int PTE_SUPER   = 1;
  localparam int PTE_WRITE   = 2;

  // Address geometry; the TLB entry layout below is built from these.
  localparam int MMU_VADDR_W   = 16;
  localparam int MMU_PADDR_W   = 19;
  localparam int MMU_PAGE_BITS = 11;
  localparam int MMU_VPN_W     = MMU_VADDR_W - MMU_PAGE_BITS;
  localparam int MMU_PFN_W     = MMU_PADDR_W - MMU_PAGE_BITS;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_WALK   = 2'd2,
    ST_RESP   = 2'd3
  } mmu_state_t;

  typedef struct packed {
    logic                 valid;
    logic [MMU_VPN_W-1:0] vpn;
    logic [MMU_PFN_W-1:0] pfn;
    logic                 super_only;
    logic                 write;
  } tlb_entry_t;

  // Returns {page_fault, prot_fault}; at most one bit is ever set.
  function automatic logic [1:0] pte_fault(input logic present,
                                           input logic super_only,
                                           input logic wr_ok,
                                           input logic umode,
                                           input logic write);
    if (!present)                return 2'b10;
    else if (umode && super_only) return 2'b01;
    else if (write && !wr_ok)     return 2'b01;
    else                          return 2'b00;
  endfunction

endpackage

// File: rtl/tlb_array.sv
// ---------------------------------------------------------------------------
// tlb_array
// Fully-associative TLB storage with combinational VPN match and a
// round-robin fill pointer.
// Config macro: TLB_WRITE_PROT_EN (adds the writable flag to each entry).
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   i_flush           invalidate every entry at the next edge (wins over fill)
//   i_lookup_vpn      VPN to match
//   o_hit/o_pfn/...   match result and cached flags
//   i_fill, i_fill_*  write an entry at the round-robin pointer
// ---------------------------------------------------------------------------
module tlb_array
  import mmu_pkg::*;
#(
  parameter int ENTRIES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_flush,
  input  logic [MMU_VPN_W-1:0] i_lookup_vpn,
  output logic                 o_hit,
  output logic [MMU_PFN_W-1:0] o_pfn,
  output logic                 o_super,
`ifdef TLB_WRITE_PROT_EN
  output logic                 o_write,
  input  logic                 i_fill_write,
`endif
  input  logic                 i_fill,
  input  logic [MMU_VPN_W-1:0] i_fill_vpn,
  input  logic [MMU_PFN_W-1:0] i_fill_pfn,
  input  logic                 i_fill_super
);

  localparam int PTR_W = $clog2(ENTRIES);

  tlb_entry_t       r_tlb [ENTRIES];
  logic [PTR_W-1:0] r_ptr;
  logic             w_fill_write;

`ifdef TLB_WRITE_PROT_EN
  assign w_fill_write = i_fill_write;
`else
  assign w_fill_write = 1'b0;
`endif

  // NOTE: only the valid bits and the pointer are reset; vpn/pfn/flag fields
  // are don't-care while invalid, so they carry no reset and just load on fill.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
      for (int i = 0; i < ENTRIES; i++) r_tlb[i].valid <= 1'b0;
    end else if (i_flush) begin
      for (int i = 0; i < ENTRIES; i++) r_tlb[i].valid <= 1'b0;
    end else if (i_fill) begin
      r_tlb[r_ptr] <= '{valid:      1'b1,
                        vpn:        i_fill_vpn,
                        pfn:        i_fill_pfn,
                        super_only: i_fill_super,
                        write:      w_fill_write};
      r_ptr <= (r_ptr == PTR_W'(ENTRIES - 1)) ? '0 : r_ptr + 1'b1;
    end
  end

  logic w_write_sel;

  // NOTE: every output gets a default before the loop, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    o_hit       = 1'b0;
    o_pfn       = '0;
    o_super     = 1'b0;
    w_write_sel = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (r_tlb[i].valid && (r_tlb[i].vpn == i_lookup_vpn)) begin
        o_hit       = 1'b1;
        o_pfn       = r_tlb[i].pfn;
        o_super     = r_tlb[i].super_only;
        w_write_sel = r_tlb[i].write;
      end
    end
  end

`ifdef TLB_WRITE_PROT_EN
  assign o_write = w_write_sel;
`else
  logic w_unused_write;
  assign w_unused_write = w_write_sel;
`endif

endmodule

// File: rtl/tlb_mmu.sv
// ---------------------------------------------------------------------------
// tlb_mmu
// Virtual-to-physical translation: small fully-associative TLB (tlb_array)
// backed by a single-level hardware page-table walk into main memory.
// Config macro: TLB_WRITE_PROT_EN (PTE bit2 enforced on stores).
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   paging_en, umode           translation enable, user-mode requester
//   ptb_load, ptb_in           load page-table base (also flushes the TLB)
//   flush                      invalidate all TLB entries
//   req_valid/ready/vaddr/write  translation request handshake
//   rsp_valid/paddr/page_fault/prot_fault  one-cycle registered response
//   mem_req/addr/rdata/ack     PTE read port toward main memory
// ---------------------------------------------------------------------------
module tlb_mmu
  import mmu_pkg::*;
#(
  parameter int VADDR_W     = MMU_VADDR_W,
  parameter int PADDR_W     = MMU_PADDR_W,
  parameter int PAGE_BITS   = MMU_PAGE_BITS,
  parameter int PTE_W       = 16,
  parameter int TLB_ENTRIES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               paging_en,
  input  logic               umode,
  input  logic               ptb_load,
  input  logic [PADDR_W-1:0] ptb_in,
  input  logic               flush,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [VADDR_W-1:0] req_vaddr,
  input  logic               req_write,
  output logic               rsp_valid,
  output logic [PADDR_W-1:0] rsp_paddr,
  output logic               rsp_page_fault,
  output logic               rsp_prot_fault,
  output logic               mem_req,
  output logic [PADDR_W-1:0] mem_addr,
  input  logic [PTE_W-1:0]   mem_rdata,
  input  logic               mem_ack
);

  localparam int VPN_W = VADDR_W - PAGE_BITS;
  localparam int PFN_W = PADDR_W - PAGE_BITS;

  mmu_state_t         r_state;
  logic               r_req_ready;
  logic [VADDR_W-1:0] r_vaddr;
  logic               r_write;
  logic               r_umode;
  logic [PADDR_W-1:0] r_ptb;
  logic               r_flushed;
  logic               r_rsp_valid;
  logic [PADDR_W-1:0] r_rsp_paddr;
  logic               r_rsp_pf;
  logic               r_rsp_prf;
  logic               r_mem_req;
  logic [PADDR_W-1:0] r_mem_addr;

  logic [VPN_W-1:0]     w_vpn;
  logic [PAGE_BITS-1:0] w_off;
  logic                 w_flush_all;
  logic                 w_tlb_hit;
  logic                 w_hit;
  logic [PFN_W-1:0]     w_tlb_pfn;
  logic                 w_tlb_super;
  logic                 w_hit_wr_ok;
  logic [PADDR_W-1:0]   w_walk_addr;
  logic                 w_pte_present;
  logic                 w_pte_super;
  logic                 w_pte_wr_ok;
  logic [PFN_W-1:0]     w_pte_pfn;
  logic [1:0]           w_hit_fault;
  logic [1:0]           w_walk_fault;
  logic                 w_fill;
  logic                 w_unused_pte;

  assign w_vpn       = r_vaddr[VADDR_W-1:PAGE_BITS];
  assign w_off       = r_vaddr[PAGE_BITS-1:0];
  assign w_flush_all = flush | ptb_load;

  // A flush on the lookup edge must make the lookup miss.
  assign w_hit = w_tlb_hit & ~w_flush_all;

  // A ptb_load coinciding with the miss points the walk at the new table.
  assign w_walk_addr = (ptb_load ? ptb_in : r_ptb) + PADDR_W'({w_vpn, 1'b0});

  assign w_pte_present = mem_rdata[PTE_PRESENT];
  assign w_pte_super   = mem_rdata[PTE_SUPER];
  assign w_pte_pfn     = mem_rdata[PTE_W-1 -: PFN_W];
  assign w_unused_pte  = ^mem_rdata;

`ifdef TLB_WRITE_PROT_EN
  logic w_tlb_write;
  assign w_hit_wr_ok = w_tlb_write;
  assign w_pte_wr_ok = mem_rdata[PTE_WRITE];
`else
  assign w_hit_wr_ok = 1'b1;
  assign w_pte_wr_ok = 1'b1;
`endif

  assign w_hit_fault  = pte_fault(1'b1, w_tlb_super, w_hit_wr_ok, r_umode, r_write);
  assign w_walk_fault = pte_fault(w_pte_present, w_pte_super, w_pte_wr_ok,
                                  r_umode, r_write);

  // Fill only present PTEs from a walk that saw no flush, including one on
  // the ack edge itself.
  assign w_fill = (r_state == ST_WALK) && mem_ack && w_pte_present &&
                  !r_flushed && !w_flush_all;

  tlb_array #(.ENTRIES(TLB_ENTRIES)) u_tlb (
    .clk          (clk),
    .reset        (reset),
    .i_flush      (w_flush_all),
    .i_lookup_vpn (w_vpn),
    .o_hit        (w_tlb_hit),
    .o_pfn        (w_tlb_pfn),
    .o_super      (w_tlb_super),
`ifdef TLB_WRITE_PROT_EN
    .o_write      (w_tlb_write),
    .i_fill_write (mem_rdata[PTE_WRITE]),
`endif
    .i_fill       (w_fill),
    .i_fill_vpn   (w_vpn),
    .i_fill_pfn   (w_pte_pfn),
    .i_fill_super (w_pte_super)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_vaddr     <= '0;
      r_write     <= 1'b0;
      r_umode     <= 1'b0;
      r_ptb       <= '0;
      r_flushed   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_paddr <= '0;
      r_rsp_pf    <= 1'b0;
      r_rsp_prf   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
    end else begin
      if (ptb_load) r_ptb <= ptb_in;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_vaddr     <= req_vaddr;
            r_write     <= req_write;
            r_umode     <= umode;
            r_req_ready <= 1'b0;
            r_state     <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (!paging_en) begin
            r_rsp_paddr <= PADDR_W'(r_vaddr);
            r_rsp_pf    <= 1'b0;
            r_rsp_prf   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else if (w_hit) begin
            r_rsp_paddr <= (|w_hit_fault) ? '0 : {w_tlb_pfn, w_off};
            r_rsp_pf    <= w_hit_fault[1];
            r_rsp_prf   <= w_hit_fault[0];
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= w_walk_addr;
            r_flushed  <= 1'b0;
            r_state    <= ST_WALK;
          end
        end
        ST_WALK: begin
          if (w_flush_all) r_flushed <= 1'b1;
          if (mem_ack) begin
            r_mem_req   <= 1'b0;
            r_rsp_paddr <= (|w_walk_fault) ? '0 : {w_pte_pfn, w_off};
            r_rsp_pf    <= w_walk_fault[1];
            r_rsp_prf   <= w_walk_fault[0];
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready      = r_req_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_paddr      = r_rsp_paddr;
  assign rsp_page_fault = r_rsp_pf;
  assign rsp_prot_fault = r_rsp_prf;
  assign mem_req        = r_mem_req;
  assign mem_addr       = r_mem_addr;

endmodule

// File: tb/tb_tlb_mmu.sv
// ---------------------------------------------------------------------------
// tb_tlb_mmu
// Directed vectors for tlb_mmu (default geometry: VPN 5 bits, PFN 8 bits,
// page offset 11 bits). Stimulus pushes the expected response onto a queue;
// a negedge monitor pops and compares whenever rsp_valid is high. A memory
// responder serves PTE reads from a table and counts walks.
// ---------------------------------------------------------------------------
module tb_tlb_mmu;

  logic        clk = 1'b0;
  logic        reset;
  logic        paging_en, umode, ptb_load, flush;
  logic [18:0] ptb_in;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_vaddr;
  logic        rsp_valid, rsp_page_fault, rsp_prot_fault;
  logic [18:0] rsp_paddr;
  logic        mem_req, mem_ack;
  logic [18:0] mem_addr;
  logic [15:0] mem_rdata;

  tlb_mmu dut (
    .clk            (clk),
    .reset          (reset),
    .paging_en      (paging_en),
    .umode          (umode),
    .ptb_load       (ptb_load),
    .ptb_in         (ptb_in),
    .flush          (flush),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_vaddr      (req_vaddr),
    .req_write      (req_write),
    .rsp_valid      (rsp_valid),
    .rsp_paddr      (rsp_paddr),
    .rsp_page_fault (rsp_page_fault),
    .rsp_prot_fault (rsp_prot_fault),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [18:0] pa;
    logic        pf;
    logic        prf;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_walks = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  bit          hold_ack = 1'b0;
  logic        mem_req_q = 1'b0;
  logic [18:0] exp_maddr = '0;
  logic [15:0] pte_mem [logic [18:0]];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [18:0] pa(input logic [7:0] pfn, input logic [10:0] off);
    return {pfn, off};
  endfunction

  always @(posedge clk) cyc++;

  // Response monitor.
  exp_t e;
  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("rsp_paddr", 32'(rsp_paddr), 32'(e.pa));
        check("rsp_page_fault", 32'(rsp_page_fault), 32'(e.pf));
        check("rsp_prot_fault", 32'(rsp_prot_fault), 32'(e.prf));
        check("rsp_latency", 32'(cyc - acc_cyc), 32'(e.lat));
      end
    end
  end

  // Page-table memory responder.
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_req) begin
      if (!mem_req_q) begin
        n_walks++;
        wait_cnt = 0;
        check("mem_addr", 32'(mem_addr), 32'(exp_maddr));
      end
      if (!hold_ack) begin
        if (wait_cnt == ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = pte_mem.exists(mem_addr) ? pte_mem[mem_addr] : 16'h0000;
          check("mem_addr_at_ack", 32'(mem_addr), 32'(exp_maddr));
        end
        wait_cnt++;
      end
    end
    mem_req_q = mem_req;
  end

  task automatic do_req(input logic [15:0] va, input logic wr, input logic um,
                        input logic [18:0] maddr, input int exp_walk,
                        input int lat, input logic [18:0] epa,
                        input logic epf, input logic eprf);
    int w0;
    int cnt;
    exp_t x;
    x.pa = epa; x.pf = epf; x.prf = eprf; x.lat = lat;
    exp_maddr = maddr;
    w0 = n_walks;
    @(negedge clk);
    cnt = 0;
    while (!req_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    sb_q.push_back(x);
    req_valid = 1'b1;
    req_vaddr = va;
    req_write = wr;
    umode     = um;
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
    cnt = 0;
    while (sb_q.size() != 0 && cnt < 40) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    if (sb_q.size() != 0) begin
      check("rsp_timeout", 32'd0, 32'd1);
      sb_q.delete();
    end
    check("walk_count", 32'(n_walks - w0), 32'(exp_walk));
  endtask

  int k;

  initial begin
    reset = 1'b1; paging_en = 1'b0; umode = 1'b0; ptb_load = 1'b0; flush = 1'b0;
    ptb_in = '0; req_valid = 1'b0; req_vaddr = '0; req_write = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;

    pte_mem[19'h102] = 16'h2A01;  // VPN1 present
    pte_mem[19'h104] = 16'h2A00;  // VPN2 not present
    pte_mem[19'h106] = 16'h2A03;  // VPN3 supervisor-only
    pte_mem[19'h108] = 16'h2A01;  // VPN4 read-only
    pte_mem[19'h10A] = 16'h2A05;  // VPN5 writable
    for (int v = 6; v <= 10; v++) pte_mem[19'h100 + 19'(2*v)] = {8'(8'h10 + v), 8'h01};
    pte_mem[19'h116] = 16'h3101;  // VPN11
    pte_mem[19'h010] = 16'h1801;  // VPN8 with ptb=0 after reset

    repeat (2) @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_paddr", 32'(rsp_paddr), 32'd0);
    check("reset_page_fault", 32'(rsp_page_fault), 32'd0);
    check("reset_prot_fault", 32'(rsp_prot_fault), 32'd0);
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_mem_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Bypass.
    do_req(16'h1234, 1'b0, 1'b0, 19'h0, 0, 1, 19'h01234, 1'b0, 1'b0);

    @(negedge clk); ptb_load = 1'b1; ptb_in = 19'h00100; paging_en = 1'b1;
    @(negedge clk); ptb_load = 1'b0;

    // Miss then hits on VPN1.
    do_req(16'h0804, 1'b0, 1'b0, 19'h102, 1, 2, 19'h15004, 1'b0, 1'b0);
    do_req(16'h0804, 1'b0, 1'b0, 19'h102, 0, 1, 19'h15004, 1'b0, 1'b0);
    do_req(16'h0FFF, 1'b0, 1'b0, 19'h102, 0, 1, 19'h157FF, 1'b0, 1'b0);

    // Not present: never cached.
    do_req(16'h1010, 1'b0, 1'b0, 19'h104, 1, 2, 19'h0, 1'b1, 1'b0);
    do_req(16'h1010, 1'b0, 1'b0, 19'h104, 1, 2, 19'h0, 1'b1, 1'b0);

    // Supervisor-only page.
    do_req(16'h1800, 1'b0, 1'b1, 19'h106, 1, 2, 19'h0, 1'b0, 1'b1);
    do_req(16'h1800, 1'b0, 1'b0, 19'h106, 0, 1, 19'h15000, 1'b0, 1'b0);
    do_req(16'h1800, 1'b0, 1'b1, 19'h106, 0, 1, 19'h0, 1'b0, 1'b1);

    // Write protection (walk path, then hit path).
`ifdef TLB_WRITE_PROT_EN
    do_req(16'h2000, 1'b1, 1'b0, 19'h108, 1, 2, 19'h0, 1'b0, 1'b1);
    do_req(16'h2000, 1'b1, 1'b0, 19'h108, 0, 1, 19'h0, 1'b0, 1'b1);
`else
    do_req(16'h2000, 1'b1, 1'b0, 19'h108, 1, 2, 19'h15000, 1'b0, 1'b0);
    do_req(16'h2000, 1'b1, 1'b0, 19'h108, 0, 1, 19'h15000, 1'b0, 1'b0);
`endif
    do_req(16'h2000, 1'b0, 1'b0, 19'h108, 0, 1, 19'h15000, 1'b0, 1'b0);
    do_req(16'h2800, 1'b1, 1'b0, 19'h10A, 1, 2, 19'h15000, 1'b0, 1'b0);
    do_req(16'h2800, 1'b1, 1'b0, 19'h10A, 0, 1, 19'h15000, 1'b0, 1'b0);

    // Flush, then fill five distinct VPNs: the first one is evicted.
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    for (int v = 6; v <= 10; v++)
      do_req(16'(v << 11), 1'b0, 1'b0, 19'h100 + 19'(2*v), 1, 2,
             pa(8'(8'h10 + v), 11'h0), 1'b0, 1'b0);
    do_req(16'h3000, 1'b0, 1'b0, 19'h10C, 1, 2, pa(8'h16, 11'h0), 1'b0, 1'b0);
    do_req(16'h4000, 1'b0, 1'b0, 19'h110, 0, 1, pa(8'h18, 11'h0), 1'b0, 1'b0);
    do_req(16'h3800, 1'b0, 1'b0, 19'h10E, 1, 2, pa(8'h17, 11'h0), 1'b0, 1'b0);

    // Flush during a slow walk: response delivered, no fill.
    ack_delay = 3;
    fork
      do_req(16'h5800, 1'b0, 1'b0, 19'h116, 1, 5, 19'h18800, 1'b0, 1'b0);
      begin
        k = 0;
        while (!mem_req && k < 20) begin
          @(posedge clk);
          #1;
          k++;
        end
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
      end
    join
    ack_delay = 0;
    do_req(16'h5800, 1'b0, 1'b0, 19'h116, 1, 2, 19'h18800, 1'b0, 1'b0);
    do_req(16'h5800, 1'b0, 1'b0, 19'h116, 0, 1, 19'h18800, 1'b0, 1'b0);

    // ptb_load also flushes.
    @(negedge clk); ptb_load = 1'b1; ptb_in = 19'h00100;
    @(negedge clk); ptb_load = 1'b0;
    do_req(16'h5800, 1'b0, 1'b0, 19'h116, 1, 2, 19'h18800, 1'b0, 1'b0);

    // Reset in the middle of a walk.
    hold_ack  = 1'b1;
    exp_maddr = 19'h118;
    @(negedge clk);
    req_valid = 1'b1; req_vaddr = 16'h6000; req_write = 1'b0; umode = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    k = 0;
    while (!mem_req && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("walk_started", 32'(mem_req), 32'd1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mem_req_on_reset", 32'(mem_req), 32'd0);
    check("ready_on_reset", 32'(req_ready), 32'd1);
    @(negedge clk);
    reset    = 1'b0;
    hold_ack = 1'b0;
    // ptb is 0 again and the TLB is empty: VPN8 walks at 0x010.
    do_req(16'h4021, 1'b0, 1'b0, 19'h010, 1, 2, 19'h0C021, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
